test_supervisor: RTL

//  Parametrised top-level test harness controller. Sequences reset into NUM_TESTS

---
 rtl/test_pkg.sv | 20 ++
 rtl/test_priority_enc.sv | 24 ++
 rtl/test_supervisor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/test_pkg.sv
// Shared types and constants for the test supervisor: FSM states, the
// outcome encoding held while DONE, and default sequencing lengths.
package test_pkg;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    RUN        = 2'd1,
    DONE       = 2'd2
  } state_t;

  // Outcome of a run; exactly one non-NONE value is held while in DONE.
  localparam logic [1:0] STATUS_NONE    = 2'd0;
  localparam logic [1:0] STATUS_PASS    = 2'd1;
  localparam logic [1:0] STATUS_FAIL    = 2'd2;
  localparam logic [1:0] STATUS_TIMEOUT = 2'd3;

  localparam int DEFAULT_RESET_CYCLES = 16;
  localparam int DEFAULT_TIMEOUT      = 4096;

endpackage

// File: rtl/test_priority_enc.sv
// Lowest-set-bit encoder: reports the index of the lowest asserted request
// and whether any request is asserted at all.
module test_priority_enc #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/test_supervisor.sv
// Test harness controller: holds the tests in reset, runs them under a cycle
// budget, and records pass / first failure / timeout until restarted.
module test_supervisor
  import test_pkg::*;
#(
  parameter int NUM_TESTS    = 5,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int CNT_W        = 16,
  parameter int IDX_W        = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_restart,
  input  logic [NUM_TESTS-1:0] i_test_fail,
  input  logic [NUM_TESTS-1:0] i_test_finish,
  output logic                 o_test_reset,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_fail,
  output logic                 o_timeout,
  output logic [IDX_W-1:0]     o_fail_index,
  output logic [NUM_TESTS-1:0] o_finished,
  output logic [CNT_W-1:0]     o_cycles
);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [1:0]           r_status;
  logic [1:0]           w_status_next;
  logic [IDX_W-1:0]     r_fail_index;
  logic [IDX_W-1:0]     w_fail_index_next;
  logic [NUM_TESTS-1:0] r_finished;
  logic [NUM_TESTS-1:0] w_finished_next;
  logic [NUM_TESTS-1:0] w_seen;
  logic [IDX_W-1:0]     w_fail_idx;
  logic                 w_fail_valid;

  test_priority_enc #(
    .N     (NUM_TESTS),
    .IDX_W (IDX_W)
  ) u_fail_enc (
    .i_req   (i_test_fail),
    .o_idx   (w_fail_idx),
    .o_valid (w_fail_valid)
  );

  assign w_seen = r_finished | i_test_finish;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= RESET_HOLD;
      r_cnt        <= '0;
      r_status     <= STATUS_NONE;
      r_fail_index <= '0;
      r_finished   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_status     <= w_status_next;
      r_fail_index <= w_fail_index_next;
      r_finished   <= w_finished_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_status_next     = r_status;
    w_fail_index_next = r_fail_index;
    w_finished_next   = r_finished;
    case (r_state)
      RESET_HOLD: begin
        if (r_cnt == CNT_W'(RESET_CYCLES - 1)) begin
          w_state_next = RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      RUN: begin
        // Exit priority is fail, then all-finished, then budget expiry.
        w_finished_next = w_seen;
        if (w_fail_valid) begin
          w_state_next      = DONE;
          w_status_next     = STATUS_FAIL;
          w_fail_index_next = w_fail_idx;
        end else if (&w_seen) begin
          w_state_next  = DONE;
          w_status_next = STATUS_PASS;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_next  = DONE;
          w_status_next = STATUS_TIMEOUT;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DONE: begin
        if (i_restart) begin
          w_state_next      = RESET_HOLD;
          w_cnt_next        = '0;
          w_status_next     = STATUS_NONE;
          w_fail_index_next = '0;
          w_finished_next   = '0;
        end
      end
      default: begin
        w_state_next = RESET_HOLD;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_test_reset = (r_state != RUN);
  assign o_running    = (r_state == RUN);
  assign o_done       = (r_state == DONE);
  assign o_pass       = (r_status == STATUS_PASS);
  assign o_fail       = (r_status == STATUS_FAIL);
  assign o_timeout    = (r_status == STATUS_TIMEOUT);
  assign o_fail_index = r_fail_index;
  assign o_finished   = r_finished;
  // The counter doubles as the reset-hold timer, so hide it outside RUN/DONE.
  assign o_cycles     = (r_state == RESET_HOLD) ? '0 : r_cnt;

endmodule
